// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared constants for the seven-segment scanner.
//   - glyph_t      : 7-bit segment vector, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK    : pattern of a dark digit (active-high)
//   - GLYPH_TABLE  : 16-entry hex glyph table, entry n at bits [7n+6:7n]
//   - glyph_lookup : nibble -> glyph helper used by sevenseg_glyph
package sevenseg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] glyph_t;

  localparam glyph_t SEG_BLANK = 7'h00;

  // Packed so it can be part-selected with a run-time nibble.
  // Listed from F down to 0 so that entry 0 lands in the low bits.
  localparam logic [16*SEG_W-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic glyph_t glyph_lookup(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/sevenseg_glyph.sv
// sevenseg_glyph
//   Combinational hex nibble to seven-segment glyph decoder (active-high).
//   Ports:
//     nibble : in  [3:0] hex digit
//     glyph  : out [6:0] segments {g,f,e,d,c,b,a}
module sevenseg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output glyph_t     glyph
);

  assign glyph = glyph_lookup(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits.
//   A prescaler divides clk into digit slots of CLK_DIV cycles; each slot
//   starts with one all-off cycle to avoid ghosting, then shows one digit.
//   Display data is double-buffered: load fills a shadow register, and the
//   active register only takes the shadow at the end of a full scan.
//   Ports:
//     clk        : in  clock, all state on rising edge
//     rst        : in  asynchronous active-high reset
//     value      : in  [4*NUM_DIGITS-1:0] hex nibbles, nibble 0 = rightmost
//     dp         : in  [NUM_DIGITS-1:0] decimal point per digit
//     blank      : in  [NUM_DIGITS-1:0] force digit dark
//     load       : in  capture value/dp/blank into the shadow register
//     lz_en      : in  leading-zero suppression (used live)
//     seg        : out [6:0] segments {g,f,e,d,c,b,a}, registered
//     seg_dp     : out decimal point segment, registered
//     dig_en     : out [NUM_DIGITS-1:0] one-hot digit select, registered
//     frame_done : out one-cycle pulse after the last slot of a scan
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Polarity masks, applied only when loading the output registers.
  localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  // ---------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             tick;
  logic             wrap_tick;

  assign tick      = (cnt_reg == CNT_LAST);
  assign wrap_tick = tick && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (tick) begin
      cnt_next = '0;
    end
  end

  always_comb begin
    idx_next = idx_reg;
    if (wrap_tick) begin
      idx_next = '0;
    end else if (tick) begin
      idx_next = idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // ---------------------------------------------------------------------
  // Shadow / active display buffers
  // ---------------------------------------------------------------------
  logic [VAL_W-1:0]      shadow_value_reg, active_value_reg;
  logic [NUM_DIGITS-1:0] shadow_dp_reg,    active_dp_reg;
  logic [NUM_DIGITS-1:0] shadow_blank_reg, active_blank_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
    end else if (load) begin
      shadow_value_reg <= value;
      shadow_dp_reg    <= dp;
      shadow_blank_reg <= blank;
    end
  end

  // Frame-boundary swap. A load landing on the same edge would only reach
  // the shadow afterwards, so it is forwarded straight to the active copy;
  // otherwise that update would be a full frame late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      active_blank_reg <= '0;
    end else if (wrap_tick) begin
      if (load) begin
        active_value_reg <= value;
        active_dp_reg    <= dp;
        active_blank_reg <= blank;
      end else begin
        active_value_reg <= shadow_value_reg;
        active_dp_reg    <= shadow_dp_reg;
        active_blank_reg <= shadow_blank_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-digit view of the active buffer
  // ---------------------------------------------------------------------
  logic [3:0]            nibble_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_dark;

  // A digit is a leading zero when it and every digit to its left are 0.
  // The rightmost digit always shows, so a value of zero still reads "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble_arr[gi] = active_value_reg[4*gi +: 4];
      if (gi == 0) begin : g_rightmost
        assign lz_dark[gi] = 1'b0;
      end else begin : g_upper
        assign lz_dark[gi] = lz_en && (active_value_reg[VAL_W-1:4*gi] == '0);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Current digit decode
  // ---------------------------------------------------------------------
  logic [3:0]            cur_nibble;
  glyph_t                cur_glyph;
  logic                  cur_blank;
  logic                  cur_suppress;
  glyph_t                seg_raw;
  logic                  dp_raw;
  logic [NUM_DIGITS-1:0] dig_raw;

  assign cur_nibble   = nibble_arr[idx_reg];
  assign cur_blank    = active_blank_reg[idx_reg];
  assign cur_suppress = lz_dark[idx_reg];

  sevenseg_glyph u_glyph (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  // Blank kills the whole digit including its point; leading-zero
  // suppression only darkens the segments so a point can still mark it.
  assign seg_raw = (cur_blank || cur_suppress) ? SEG_BLANK : cur_glyph;
  assign dp_raw  = active_dp_reg[idx_reg] && !cur_blank;
  assign dig_raw = NUM_DIGITS'(1) << idx_reg;

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  // On the tick edge the index moves on, so the cycle that follows is
  // driven dark on every line; the new digit appears one cycle later with
  // matching segments because both come from the same idx_reg.
  glyph_t                seg_next;
  logic                  seg_dp_next;
  logic [NUM_DIGITS-1:0] dig_en_next;

  always_comb begin
    seg_next    = seg_raw;
    seg_dp_next = dp_raw;
    dig_en_next = dig_raw;
    if (tick) begin
      seg_next    = SEG_BLANK;
      seg_dp_next = 1'b0;
      dig_en_next = '0;
    end
  end

  logic [6:0]            seg_reg;
  logic                  seg_dp_reg;
  logic [NUM_DIGITS-1:0] dig_en_reg;
  logic                  frame_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg        <= SEG_BLANK ^ SEG_POL;
      seg_dp_reg     <= SEG_ACTIVE_LOW;
      dig_en_reg     <= DIG_POL;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next ^ SEG_POL;
      seg_dp_reg     <= seg_dp_next ^ SEG_ACTIVE_LOW;
      dig_en_reg     <= dig_en_next ^ DIG_POL;
      frame_done_reg <= wrap_tick;
    end
  end

  assign seg        = seg_reg;
  assign seg_dp     = seg_dp_reg;
  assign dig_en     = dig_en_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
//   Directed bench for sevenseg_scan with NUM_DIGITS=4, CLK_DIV=4.
//   Two instances share all inputs: dut (active-high outputs) and dut_n
//   (active-low segments and digit selects). Expected slot contents are
//   queued by the stimulus sequence and checked by a monitor at the first
//   lit cycle of each slot.
module tb_sevenseg_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        lz_en;

  logic [6:0]  seg,   seg_n;
  logic        seg_dp, seg_dp_n;
  logic [3:0]  dig_en, dig_en_n;
  logic        frame_done, frame_done_n;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];

  sevenseg_scan #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank),
    .load(load), .lz_en(lz_en),
    .seg(seg), .seg_dp(seg_dp), .dig_en(dig_en), .frame_done(frame_done)
  );

  sevenseg_scan #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank),
    .load(load), .lz_en(lz_en),
    .seg(seg_n), .seg_dp(seg_dp_n), .dig_en(dig_en_n), .frame_done(frame_done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [6:0] s, input logic p);
    exp_t e;
    e.dig = d;
    e.seg = s;
    e.dp  = p;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] p);
    push(4'b0001, s0, p[0]);
    push(4'b0010, s1, p[1]);
    push(4'b0100, s2, p[2]);
    push(4'b1000, s3, p[3]);
  endtask

  // Wait (bounded) for the next frame_done pulse; a timeout is a failure.
  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    check(tag, {31'd0, frame_done}, 32'd1);
  endtask

  // Wait (bounded) until every queued slot has been observed.
  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
    value = v;
    dp    = p;
    blank = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Monitor: slot contents, dead-time, frame_done width/period
  // ---------------------------------------------------------------------
  int         cyc      = 0;
  int         last_fd  = 0;
  bit         fd_valid = 1'b0;
  logic       prev_fd  = 1'b0;
  logic [3:0] prev_dig = '0;
  int         dead_len = 0;
  exp_t       mon_e;
  logic [6:0] inv_seg;
  logic [3:0] inv_dig;
  logic       inv_dp;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_dig = '0;
      prev_fd  = 1'b0;
      fd_valid = 1'b0;
      dead_len = 0;
    end else begin
      if (frame_done === 1'b1) begin
        check("fd_single_cycle", {31'd0, prev_fd}, 32'd0);
        if (!prev_fd && fd_valid) begin
          check("fd_period", cyc - last_fd, 16);
        end
        last_fd  = cyc;
        fd_valid = 1'b1;
      end

      if (dig_en != 4'b0000) begin
        if (prev_dig == 4'b0000 && q.size() > 0) begin
          mon_e   = q.pop_front();
          inv_seg = ~mon_e.seg;
          inv_dig = ~mon_e.dig;
          inv_dp  = ~mon_e.dp;
          $display("slot dig_en=%b seg=%h dp=%b | exp dig_en=%b seg=%h dp=%b",
                   dig_en, seg, seg_dp, mon_e.dig, mon_e.seg, mon_e.dp);
          check("slot_dig_en", dig_en, mon_e.dig);
          check("slot_seg", seg, mon_e.seg);
          check("slot_dp", seg_dp, mon_e.dp);
          check("slot_dead_len", dead_len, 1);
          check("slot_seg_n", seg_n, inv_seg);
          check("slot_dig_en_n", dig_en_n, inv_dig);
          check("slot_dp_n", seg_dp_n, inv_dp);
        end
        dead_len = 0;
      end else begin
        dead_len++;
        if (q.size() > 0) begin
          check("dead_seg", seg, 7'h00);
          check("dead_dp", seg_dp, 1'b0);
          check("dead_seg_n", seg_n, 7'h7F);
          check("dead_dig_en_n", dig_en_n, 4'hF);
        end
      end
      prev_dig = dig_en;
      prev_fd  = frame_done;
    end
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int n;
    rst   = 1'b1;
    value = '0;
    dp    = '0;
    blank = '0;
    load  = 1'b0;
    lz_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    $display("reset: seg=%h dig_en=%b seg_n=%h dig_en_n=%b", seg, dig_en, seg_n, dig_en_n);
    check("rst_seg", seg, 7'h00);
    check("rst_dp", seg_dp, 1'b0);
    check("rst_dig_en", dig_en, 4'b0000);
    check("rst_fd", frame_done, 1'b0);
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_dp_n", seg_dp_n, 1'b1);
    check("rst_dig_en_n", dig_en_n, 4'hF);
    check("rst_fd_n", frame_done_n, 1'b0);

    // First slot after release shows zero on digit 0; first tick after 4 clocks
    rst = 1'b0;
    @(negedge clk);
    check("start_dig_en", dig_en, 4'b0001);
    check("start_seg", seg, 7'h3F);
    repeat (3) @(negedge clk);
    check("first_tick_dead", dig_en, 4'b0000);
    @(negedge clk);
    check("second_slot", dig_en, 4'b0010);

    // Plain hex frame
    $display("txn: load 12AF");
    do_load(16'h12AF, 4'b0000, 4'b0000);
    wait_fd("fd_12AF");
    push_frame(7'h71, 7'h77, 7'h5B, 7'h06, 4'b0000);
    drain("drain_12AF");

    // Leading-zero suppression
    $display("txn: load 0040 lz_en=1");
    lz_en = 1'b1;
    do_load(16'h0040, 4'b0000, 4'b0000);
    wait_fd("fd_0040");
    push_frame(7'h3F, 7'h66, 7'h00, 7'h00, 4'b0000);
    drain("drain_0040");

    // Blank overrides its decimal point
    $display("txn: load 8888 blank=0100 dp=0100");
    do_load(16'h8888, 4'b0100, 4'b0100);
    wait_fd("fd_blank");
    push_frame(7'h7F, 7'h7F, 7'h00, 7'h7F, 4'b0000);
    drain("drain_blank");

    // Suppressed digit keeps its decimal point
    $display("txn: load 0005 dp=1000 lz_en=1");
    do_load(16'h0005, 4'b1000, 4'b0000);
    wait_fd("fd_lzdp");
    push_frame(7'h6D, 7'h00, 7'h00, 7'h00, 4'b1000);
    drain("drain_lzdp");

    // Mid-frame load must not tear the frame in progress
    $display("txn: show 2222 then load 1111 mid-frame");
    lz_en = 1'b0;
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_fd("fd_2222");
    push_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000);
    n = 0;
    while (q.size() > 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("midframe_slot0_seen", q.size(), 3);
    do_load(16'h1111, 4'b0000, 4'b0000);
    drain("drain_2222");
    wait_fd("fd_1111");
    push_frame(7'h06, 7'h06, 7'h06, 7'h06, 4'b0000);
    drain("drain_1111");

    // Load coinciding with the wrap tick goes straight to the display
    $display("txn: load FFFF on wrap tick");
    wait_fd("fd_align");
    value = 16'hFFFF;
    repeat (15) @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("wrap_fd", frame_done, 1'b1);
    push_frame(7'h71, 7'h71, 7'h71, 7'h71, 4'b0000);
    drain("drain_FFFF");

    // Asynchronous reset mid-scan
    $display("txn: async reset mid-scan");
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_seg", seg, 7'h00);
    check("async_dig_en", dig_en, 4'b0000);
    check("async_seg_n", seg_n, 7'h7F);
    check("async_dp_n", seg_dp_n, 1'b1);
    check("async_dig_en_n", dig_en_n, 4'hF);
    check("async_fd_n", frame_done_n, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_hold_fd", frame_done, 1'b0);
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    check("first_fd_after_rst", n, 16);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    drain("drain_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
